// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-order pipeline hazard control with a latency-tracked destination scoreboard.
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  parameter int LAT_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic                      id_wr_i,
  input  logic [REG_AW-1:0]         id_dest_i,
  input  logic [LAT_W-1:0]          id_lat_i,
  input  logic                      ex_branch_taken_i,
  input  logic                      mem_busy_i,
  output logic                      pc_en_o,
  output logic                      ifid_en_o,
  output logic                      ifid_flush_o,
  output logic                      idex_flush_o,
  output logic                      sb_full_o,
  output logic [CNT_W-1:0]          stall_count_o
);
  localparam logic [DEPTH-1:0] D1 = 1;
  localparam logic [LAT_W-1:0] L1 = 1;
  localparam logic [CNT_W-1:0] C1 = 1;
  logic [DEPTH-1:0] valid_q, valid_d, match, free;
  logic [REG_AW-1:0] dest_q [DEPTH];
  logic [REG_AW-1:0] dest_d [DEPTH];
  logic [LAT_W-1:0] cnt_q [DEPTH];
  logic [LAT_W-1:0] cnt_d [DEPTH];
  logic [LAT_W-1:0] dec [DEPTH];
  logic [CNT_W-1:0] stall_q, stall_d;
  logic hit, full, need_alloc, full_stall, dstall, stall_cyc, alloc;
  always_comb begin
    hit = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      match[j] = valid_q[j] && dest_q[j] == id_dest_i;
      for (int i = 0; i < NUM_SRC; i++)
        hit = hit | (id_src_used_i[i] && id_src_i[i*REG_AW +: REG_AW] != '0 &&
                     valid_q[j] && id_src_i[i*REG_AW +: REG_AW] == dest_q[j]);
    end
  end
  // lowest clear bit of valid_q: entries freed this edge are not visible yet
  assign free       = ~valid_q & (valid_q + D1);
  assign full       = &valid_q;
  assign need_alloc = id_valid_i & id_wr_i & (id_dest_i != '0) & (id_lat_i != '0);
  assign full_stall = need_alloc & full & ~|match;
  assign dstall     = id_valid_i & (hit | full_stall);
  assign stall_cyc  = ~mem_busy_i & ~ex_branch_taken_i & dstall;
  assign alloc      = ~mem_busy_i & ~ex_branch_taken_i & ~dstall & need_alloc;
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      dec[j]     = cnt_q[j] - L1;
      valid_d[j] = mem_busy_i ? valid_q[j] : valid_q[j] && cnt_q[j] != L1;
      cnt_d[j]   = mem_busy_i || !valid_q[j] ? cnt_q[j] : dec[j];
      dest_d[j]  = dest_q[j];
      if (alloc && (match[j] || (~|match && free[j]))) begin
        valid_d[j] = 1'b1;
        dest_d[j]  = id_dest_i;
        cnt_d[j]   = match[j] && dec[j] > id_lat_i ? dec[j] : id_lat_i;
      end
    end
  end
  assign stall_d = stall_cyc && stall_q != '1 ? stall_q + C1 : stall_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
    dest_q <= dest_d;
    cnt_q  <= cnt_d;
  end
  assign pc_en_o       = ~rst_i & ~mem_busy_i & (ex_branch_taken_i | ~dstall);
  assign ifid_en_o     = pc_en_o;
  assign ifid_flush_o  = rst_i | (~mem_busy_i & ex_branch_taken_i);
  assign idex_flush_o  = rst_i | (~mem_busy_i & (ex_branch_taken_i | dstall));
  assign sb_full_o     = ~rst_i & full;
  assign stall_count_o = stall_q;
endmodule
